// File: rtl/dram_wr_arbiter.sv
// Two-requester write arbiter in front of a 64x4 asynchronous-read RAM.
// A full clear sweep runs after reset and on request; round-robin resolves conflicts.
module dram_wr_arbiter #(
  parameter logic [3:0] CLEAR_DATA = 4'h0,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_req,
  input  logic             wr0_valid,
  output logic             wr0_ready,
  input  logic [5:0]       wr0_addr,
  input  logic [3:0]       wr0_data,
  input  logic             wr1_valid,
  output logic             wr1_ready,
  input  logic [5:0]       wr1_addr,
  input  logic [3:0]       wr1_data,
  input  logic [5:0]       rd_addr,
  output logic [3:0]       rd_data,
  output logic             busy,
  output logic [CNT_W-1:0] wr_count,
  output logic [7:0]       conflict_count
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t           state_reg, state_next;
  logic [5:0]       sweep_reg, sweep_next;
  logic             last_grant_reg, last_grant_next;
  logic [CNT_W-1:0] wr_count_reg, wr_count_next;
  logic [7:0]       conflict_count_reg, conflict_count_next;

  logic             mem_we;
  logic [5:0]       mem_waddr;
  logic [3:0]       mem_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= CLEAR;
      sweep_reg          <= 6'd0;
      last_grant_reg     <= 1'b1;
      wr_count_reg       <= '0;
      conflict_count_reg <= 8'd0;
    end else begin
      state_reg          <= state_next;
      sweep_reg          <= sweep_next;
      last_grant_reg     <= last_grant_next;
      wr_count_reg       <= wr_count_next;
      conflict_count_reg <= conflict_count_next;
    end
  end

  // last_grant_reg = 1 means requester 1 won the most recent write, so requester 0 wins the next conflict.
  always_comb begin
    state_next          = state_reg;
    sweep_next          = sweep_reg;
    last_grant_next     = last_grant_reg;
    wr_count_next       = wr_count_reg;
    conflict_count_next = conflict_count_reg;
    wr0_ready           = 1'b0;
    wr1_ready           = 1'b0;
    mem_we              = 1'b0;
    mem_waddr           = sweep_reg;
    mem_wdata           = CLEAR_DATA;
    busy                = 1'b1;
    if (!rst) begin
      case (state_reg)
        CLEAR: begin
          mem_we     = 1'b1;
          sweep_next = sweep_reg + 6'd1;
          if (sweep_reg == 6'd63) state_next = RUN;
        end
        RUN: begin
          busy = 1'b0;
          if (wr0_valid && wr1_valid && conflict_count_reg != 8'hFF)
            conflict_count_next = conflict_count_reg + 8'd1;
          if (clear_req) begin
            state_next = CLEAR;
            sweep_next = 6'd0;
          end else begin
            wr0_ready = wr0_valid && (!wr1_valid || last_grant_reg);
            wr1_ready = wr1_valid && (!wr0_valid || !last_grant_reg);
            if (wr0_ready) begin
              mem_we          = 1'b1;
              mem_waddr       = wr0_addr;
              mem_wdata       = wr0_data;
              last_grant_next = 1'b0;
            end else if (wr1_ready) begin
              mem_we          = 1'b1;
              mem_waddr       = wr1_addr;
              mem_wdata       = wr1_data;
              last_grant_next = 1'b1;
            end
            if (mem_we && wr_count_reg != {CNT_W{1'b1}})
              wr_count_next = wr_count_reg + CNT_W'(1);
          end
        end
        default: state_next = CLEAR;
      endcase
    end
  end

  // Four 64x1 bit planes sharing one write address: the DIA..DID slices of a RAM64M.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_plane
      logic bit_plane [64];
      always_ff @(posedge clk) begin
        if (mem_we) bit_plane[mem_waddr] <= mem_wdata[gi];
      end
      assign rd_data[gi] = bit_plane[rd_addr];
    end
  endgenerate

  assign wr_count       = wr_count_reg;
  assign conflict_count = conflict_count_reg;

endmodule

// File: tb/tb_dram_wr_arbiter.sv
// Randomized scoreboard bench for dram_wr_arbiter: a transaction-level model predicts
// every cycle's outputs, a monitor on the falling edge pops and compares them.
module tb_dram_wr_arbiter;

  localparam logic [3:0] CD = 4'h9;
  localparam int         CW = 16;

  logic          clk;
  logic          rst, clear_req;
  logic          wr0_valid, wr0_ready, wr1_valid, wr1_ready;
  logic [5:0]    wr0_addr, wr1_addr, rd_addr;
  logic [3:0]    wr0_data, wr1_data, rd_data;
  logic          busy;
  logic [CW-1:0] wr_count;
  logic [7:0]    conflict_count;

  dram_wr_arbiter #(.CLEAR_DATA(CD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .clear_req(clear_req),
    .wr0_valid(wr0_valid), .wr0_ready(wr0_ready), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_valid(wr1_valid), .wr1_ready(wr1_ready), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
    .wr_count(wr_count), .conflict_count(conflict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy;
    logic        r0;
    logic        r1;
    logic [3:0]  rd;
    logic        rd_known;
    logic [15:0] wrc;
    logic [7:0]  cfc;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0, pushed = 0, popped = 0;

  // Reference model: state as seen right after a reset edge.
  bit         m_clear = 1'b1;
  int         m_sweep = 0;
  int         last_winner = 1;
  int         m_wrc = 0;
  int         m_cfc = 0;
  logic [3:0] m_mem [64];
  bit         m_known [64];
  bit         acc0, acc1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        popped++;
        chk("busy", {31'd0, busy}, {31'd0, e.busy});
        chk("wr0_ready", {31'd0, wr0_ready}, {31'd0, e.r0});
        chk("wr1_ready", {31'd0, wr1_ready}, {31'd0, e.r1});
        chk("wr_count", {16'd0, wr_count}, {16'd0, e.wrc});
        chk("conflict_count", {24'd0, conflict_count}, {24'd0, e.cfc});
        if (e.rd_known) chk("rd_data", {28'd0, rd_data}, {28'd0, e.rd});
      end
    end
  end

  // Called with this cycle's inputs applied; predicts outputs, advances the model, moves to the next cycle.
  task automatic step();
    exp_t e;
    bit   g0, g1;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst && !m_clear && !clear_req) begin
      if (wr0_valid && wr1_valid) begin
        if (last_winner == 1) g0 = 1'b1; else g1 = 1'b1;
      end else begin
        g0 = wr0_valid;
        g1 = wr1_valid;
      end
    end
    e.busy     = rst || m_clear;
    e.r0       = g0;
    e.r1       = g1;
    e.rd       = m_mem[rd_addr];
    e.rd_known = m_known[rd_addr];
    e.wrc      = 16'(m_wrc);
    e.cfc      = 8'(m_cfc);
    q.push_back(e);
    pushed++;
    acc0 = g0;
    acc1 = g1;
    if (rst) begin
      m_clear = 1'b1; m_sweep = 0; last_winner = 1; m_wrc = 0; m_cfc = 0;
    end else if (m_clear) begin
      m_mem[m_sweep] = CD;
      m_known[m_sweep] = 1'b1;
      if (m_sweep == 63) m_clear = 1'b0;
      m_sweep = (m_sweep + 1) % 64;
    end else begin
      if (wr0_valid && wr1_valid && m_cfc < 255) m_cfc++;
      if (clear_req) begin
        m_clear = 1'b1;
        m_sweep = 0;
      end else if (g0 || g1) begin
        if (g0) begin m_mem[wr0_addr] = wr0_data; m_known[wr0_addr] = 1'b1; last_winner = 0; end
        else    begin m_mem[wr1_addr] = wr1_data; m_known[wr1_addr] = 1'b1; last_winner = 1; end
        if (m_wrc < 65535) m_wrc++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr0_valid = 1'b0;
    wr1_valid = 1'b0;
    clear_req = 1'b0;
  endtask

  // Random traffic that respects the hold-while-stalled rule.
  task automatic run_random(int n, int pv, bit allow_clear);
    for (int i = 0; i < n; i++) begin
      if (!(wr0_valid && !acc0)) begin
        wr0_valid = ($urandom_range(99) < pv);
        wr0_addr  = 6'($urandom);
        wr0_data  = 4'($urandom);
      end
      if (!(wr1_valid && !acc1)) begin
        wr1_valid = ($urandom_range(99) < pv);
        wr1_addr  = 6'($urandom);
        wr1_data  = 4'($urandom);
      end
      rd_addr   = 6'($urandom);
      clear_req = allow_clear && ($urandom_range(99) == 0);
      step();
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) m_known[i] = 1'b0;
    rst = 1'b1; clear_req = 1'b0; rd_addr = 6'd0;
    wr0_valid = 1'b0; wr0_addr = 6'd0; wr0_data = 4'd0;
    wr1_valid = 1'b0; wr1_addr = 6'd0; wr1_data = 4'd0;
    acc0 = 1'b0; acc1 = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b0;
    // Post-reset sweep, then read back every address.
    for (int i = 0; i < 64; i++) begin rd_addr = 6'(i); step(); end
    for (int i = 0; i < 64; i++) begin rd_addr = 6'(i); step(); end

    // Simultaneous requests: requester 0 first, then requester 1.
    wr0_valid = 1'b1; wr0_addr = 6'd5; wr0_data = 4'hA;
    wr1_valid = 1'b1; wr1_addr = 6'd6; wr1_data = 4'h3;
    rd_addr = 6'd5;
    step();
    step();
    idle();
    rd_addr = 6'd5; step();
    rd_addr = 6'd6; step();

    // Requester 1 alone for three cycles.
    for (int i = 1; i <= 3; i++) begin
      wr1_valid = 1'b1; wr1_addr = 6'(i); wr1_data = 4'(i + 4);
      rd_addr = 6'(i);
      step();
    end
    idle();
    for (int i = 1; i <= 3; i++) begin rd_addr = 6'(i); step(); end

    // clear_req wins over a pending write.
    wr0_valid = 1'b1; wr0_addr = 6'd7; wr0_data = 4'h2; clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int i = 0; i < 64; i++) begin
      clear_req = (i == 10);
      rd_addr = 6'($urandom);
      step();
    end
    idle();
    for (int i = 0; i < 8; i++) begin rd_addr = 6'(i); step(); end

    run_random(400, 60, 1'b1);

    // Reset at sweep address 30.
    clear_req = 1'b1; step();
    clear_req = 1'b0;
    for (int i = 0; i < 30; i++) step();
    rst = 1'b1; step(); step();
    rst = 1'b0;
    for (int i = 0; i < 70; i++) begin rd_addr = 6'($urandom); step(); end

    run_random(300, 80, 1'b0);

    // Reset in the middle of RUN.
    rst = 1'b1; step();
    rst = 1'b0;
    for (int i = 0; i < 66; i++) begin rd_addr = 6'(i); step(); end

    // Saturation of both counters.
    for (int i = 0; i < 70000; i++) begin
      wr0_valid = 1'b1; wr0_addr = 6'($urandom); wr0_data = 4'($urandom);
      rd_addr = 6'($urandom);
      step();
    end
    wr1_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      wr0_addr = 6'($urandom); wr0_data = 4'($urandom);
      wr1_addr = 6'($urandom); wr1_data = 4'($urandom);
      step();
    end
    idle();
    for (int i = 0; i < 64; i++) begin rd_addr = 6'(i); step(); end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", popped, pushed);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
